// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response and RAM bus bundle around mem_ctrl.
//   LSB side   : ls_sig, load_or_store, len, ls_addr, store_val -> ls_done, ls_data
//   Fetch side : if_sig, if_addr -> if_done, if_inst
//   RAM side   : mem_din, io_buffer_full -> mem_dout, mem_a, mem_wr
// Modports: slave = mem_ctrl, master = requesters plus RAM/IO model.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  ls_sig;
   logic                  load_or_store;
   logic [2:0]            len;
   logic [ADDR_WIDTH-1:0] ls_addr;
   logic [31:0]           store_val;
   logic                  ls_done;
   logic [31:0]           ls_data;

   logic                  if_sig;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_done;
   logic [31:0]           if_inst;

   logic [7:0]            mem_din;
   logic [7:0]            mem_dout;
   logic [ADDR_WIDTH-1:0] mem_a;
   logic                  mem_wr;
   logic                  io_buffer_full;

   modport slave (
      input  ls_sig, load_or_store, len, ls_addr, store_val,
      input  if_sig, if_addr,
      input  mem_din, io_buffer_full,
      output ls_done, ls_data, if_done, if_inst,
      output mem_dout, mem_a, mem_wr
   );

   modport master (
      output ls_sig, load_or_store, len, ls_addr, store_val,
      output if_sig, if_addr,
      output mem_din, io_buffer_full,
      input  ls_done, ls_data, if_done, if_inst,
      input  mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and 4-byte instruction fetches onto a
// byte-wide RAM port with 1-cycle read latency.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable, low freezes), clear (flush)
//   bus (mem_ctrl_if.slave): LSB request/response, fetch request/response, RAM bus
// Optional: define MEM_CTRL_IO_STALL_EN to hold store bytes aimed at IO space
// (address >= IO_BASE) while io_buffer_full is high.
// All outputs are registered except mem_wr, which is gated by rdy (and the IO stall).
module mem_ctrl #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h0003_0000)
) (
   input logic       clk,
   input logic       rst,
   input logic       rdy,
   input logic       clear,
   mem_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STORE,
      S_FETCH,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  ls_done_q, ls_done_d;
   logic [31:0]           ls_data_q, ls_data_d;
   logic                  if_done_q, if_done_d;
   logic [31:0]           if_inst_q, if_inst_d;
   logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
   logic [7:0]            mem_dout_q, mem_dout_d;
   logic                  mem_wr_q, mem_wr_d;

   // While frozen the RAM keeps reading the held address, so the byte that was
   // in flight when rdy dropped is parked here and used on the first active cycle.
   logic                  rdy_prev_q;
   logic [7:0]            din_hold_q;
   logic [7:0]            din_c;
   logic                  stall_c;

   logic [CNT_W-1:0]      cnt_inc_c;
   logic [1:0]            ld_idx_c;
   logic [1:0]            st_idx_c;

   // One-hot length to byte count; anything unexpected is treated as a word.
   function automatic logic [CNT_W-1:0] len_to_n(input logic [2:0] len);
      case (len)
         3'b001:  len_to_n = CNT_W'(1);
         3'b010:  len_to_n = CNT_W'(2);
         default: len_to_n = CNT_W'(4);
      endcase
   endfunction

`ifdef MEM_CTRL_IO_STALL_EN
   assign stall_c = (state_q == S_STORE) && (mem_a_q >= IO_BASE) && bus.io_buffer_full;
`else
   logic unused_io_c;
   assign unused_io_c = bus.io_buffer_full ^ (^IO_BASE);
   assign stall_c     = 1'b0;
`endif

   assign din_c = rdy_prev_q ? bus.mem_din : din_hold_q;

   // Next-state and output logic; everything holds when rdy is low.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      n_d        = n_q;
      cnt_d      = cnt_q;
      wdata_d    = wdata_q;
      ls_done_d  = ls_done_q;
      ls_data_d  = ls_data_q;
      if_done_d  = if_done_q;
      if_inst_d  = if_inst_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      cnt_inc_c  = cnt_q + CNT_W'(1);
      ld_idx_c   = 2'(cnt_q - CNT_W'(1));
      st_idx_c   = 2'(cnt_inc_c);

      if (rdy) begin
         case (state_q)
            S_IDLE: begin
               if (!ls_done_q && !if_done_q) begin
                  if (bus.ls_sig) begin
                     addr_d  = bus.ls_addr;
                     n_d     = len_to_n(bus.len);
                     cnt_d   = '0;
                     mem_a_d = bus.ls_addr;
                     if (bus.load_or_store) begin
                        wdata_d    = bus.store_val;
                        mem_dout_d = bus.store_val[7:0];
                        mem_wr_d   = 1'b1;
                        state_d    = S_STORE;
                     end else begin
                        wdata_d  = '0;
                        mem_wr_d = 1'b0;
                        state_d  = S_LOAD;
                     end
                  end else if (bus.if_sig && !clear) begin
                     addr_d   = bus.if_addr;
                     n_d      = CNT_W'(4);
                     cnt_d    = '0;
                     wdata_d  = '0;
                     mem_a_d  = bus.if_addr;
                     mem_wr_d = 1'b0;
                     state_d  = S_FETCH;
                  end
               end
            end

            // cnt_q is the index of the address on mem_a; the byte for index
            // cnt_q-1 is arriving on mem_din this cycle.
            S_LOAD, S_FETCH: begin
               if (state_q == S_FETCH && clear) begin
                  state_d  = S_IDLE;
                  mem_wr_d = 1'b0;
               end else begin
                  cnt_d = cnt_inc_c;
                  if (cnt_q != '0) begin
                     wdata_d[{ld_idx_c, 3'b000} +: 8] = din_c;
                  end
                  if (cnt_inc_c < n_q) begin
                     mem_a_d = addr_q + ADDR_WIDTH'(cnt_inc_c);
                  end
                  if (cnt_q == n_q) begin
                     state_d = S_DONE;
                     if (state_q == S_FETCH) begin
                        if_done_d = 1'b1;
                        if_inst_d = wdata_d;
                     end else begin
                        ls_done_d = 1'b1;
                        ls_data_d = wdata_d;
                     end
                  end
               end
            end

            // cnt_q is the index of the byte being written this cycle.
            S_STORE: begin
               if (!stall_c) begin
                  if (cnt_inc_c < n_q) begin
                     cnt_d      = cnt_inc_c;
                     mem_a_d    = addr_q + ADDR_WIDTH'(cnt_inc_c);
                     mem_dout_d = wdata_q[{st_idx_c, 3'b000} +: 8];
                  end else begin
                     state_d   = S_DONE;
                     mem_wr_d  = 1'b0;
                     ls_done_d = 1'b1;
                  end
               end
            end

            S_DONE: begin
               state_d   = S_IDLE;
               ls_done_d = 1'b0;
               if_done_d = 1'b0;
               mem_wr_d  = 1'b0;
            end

            default: begin
               state_d  = S_IDLE;
               mem_wr_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         n_q        <= '0;
         cnt_q      <= '0;
         wdata_q    <= '0;
         ls_done_q  <= 1'b0;
         ls_data_q  <= '0;
         if_done_q  <= 1'b0;
         if_inst_q  <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         n_q        <= n_d;
         cnt_q      <= cnt_d;
         wdata_q    <= wdata_d;
         ls_done_q  <= ls_done_d;
         ls_data_q  <= ls_data_d;
         if_done_q  <= if_done_d;
         if_inst_q  <= if_inst_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
      end
   end

   // Read-data parking across rdy-low windows.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_prev_q <= 1'b1;
         din_hold_q <= '0;
      end else begin
         rdy_prev_q <= rdy;
         if (rdy_prev_q) begin
            din_hold_q <= bus.mem_din;
         end
      end
   end

   assign bus.ls_done  = ls_done_q;
   assign bus.ls_data  = ls_data_q;
   assign bus.if_done  = if_done_q;
   assign bus.if_inst  = if_inst_q;
   assign bus.mem_a    = mem_a_q;
   assign bus.mem_dout = mem_dout_q;
   assign bus.mem_wr   = mem_wr_q && rdy && !stall_c;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a
// transaction-level model (byte array + latency rules), with a byte RAM model
// on the bus. Honours MEM_CTRL_IO_STALL_EN when it is defined for the build.
module tb_mem_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic rdy;
   logic clear;

   mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

   mem_ctrl #(.ADDR_WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  dev_mem [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic [31:0] tr_a    [0:63];
   logic        tr_wr   [0:63];
   logic [7:0]  tr_dout [0:63];
   int          wr_total  = 0;
   int          frozen_wr = 0;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: little-endian read of n bytes, upper bytes zero, address wraps.
   function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
      logic [31:0] r;
      logic [31:0] ai;
      r = '0;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         r  = r | (32'(ref_mem[ai[9:0]]) << (8 * i));
      end
      return r;
   endfunction

   task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] v);
      logic [31:0] ai;
      for (int i = 0; i < n; i++) begin
         ai = a + 32'(i);
         ref_mem[ai[9:0]] = 8'(v >> (8 * i));
      end
   endtask

   // Byte RAM with 1-cycle read latency; initialised while rst is high.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) dev_mem[i] <= init_byte(i);
      end else if (bus.mem_wr) begin
         dev_mem[bus.mem_a[9:0]] <= bus.mem_dout;
      end
      bus.mem_din <= dev_mem[bus.mem_a[9:0]];
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_wr) wr_total++;
         if (bus.mem_wr && !rdy) frozen_wr++;
      end
   end

   // One request (kind 0 load, 1 store, 2 fetch) issued at cycle 0, entered at
   // posedge+1 with the DUT idle. done_cyc = cycle index of the done pulse
   // (-1 if none), act = rdy-high edges before it, wrs = RAM write cycles.
   task automatic xact(input int kind, input logic [31:0] addr, input int n,
                       input logic [31:0] sval, input logic [31:0] low_mask,
                       input logic [31:0] full_mask, input int clr_cyc, input bit rnd,
                       output int done_cyc, output int act, output logic [31:0] data,
                       output int wrs);
      bit seen;
      bit flushed;
      bit r;
      int w0;
      seen = 0; flushed = 0; done_cyc = -1; act = 0; data = '0; w0 = wr_total;
      if (kind == 2) begin
         bus.if_sig  = 1'b1;
         bus.if_addr = addr;
      end else begin
         bus.ls_sig        = 1'b1;
         bus.load_or_store = (kind == 1);
         bus.len           = 3'(n);
         bus.ls_addr       = addr;
         bus.store_val     = sval;
      end
      for (int c = 0; c < 200; c++) begin
         if (rnd) rdy = ($urandom_range(0, 3) != 0);
         else     rdy = (c < 32) ? !low_mask[c] : 1'b1;
         bus.io_buffer_full = (c < 32) ? full_mask[c] : 1'b0;
         clear = (c == clr_cyc);
         if (clear && kind == 2) begin
            bus.if_sig = 1'b0;
            flushed    = 1;
         end
         @(negedge clk);
         if (c < 64) begin
            tr_a[c] = bus.mem_a; tr_wr[c] = bus.mem_wr; tr_dout[c] = bus.mem_dout;
         end
         if ((kind == 2) ? bus.if_done : bus.ls_done) begin
            seen = 1; done_cyc = c;
            data = (kind == 2) ? bus.if_inst : bus.ls_data;
            break;
         end
         if (flushed && c >= clr_cyc + 12) break;
         if (rdy) act++;
         @(posedge clk); #1;
      end
      clear = 1'b0;
      bus.io_buffer_full = 1'b0;
      wrs = wr_total - w0;
      if (seen) begin
         r = rdy;
         @(posedge clk); #1;
         if (!r) begin
            rdy = 1'b1;
            @(negedge clk);
            chk("done_stretch", 32'((kind == 2) ? bus.if_done : bus.ls_done), 32'd1);
            @(posedge clk); #1;
         end
      end else begin
         @(posedge clk); #1;
      end
      bus.ls_sig = 1'b0;
      bus.if_sig = 1'b0;
      rdy = 1'b1;
   endtask

   initial begin
      int dc, act, wrs, ls_c, if_c, kind, n, bad;
      logic [31:0] d, ld, id, addr, sval;

      rst = 1'b1; rdy = 1'b1; clear = 1'b0;
      bus.ls_sig = 1'b0; bus.load_or_store = 1'b0; bus.len = 3'b001; bus.ls_addr = '0;
      bus.store_val = '0; bus.if_sig = 1'b0; bus.if_addr = '0; bus.io_buffer_full = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ls_done", 32'(bus.ls_done), 32'd0);
      chk("rst_ls_data", bus.ls_data, 32'd0);
      chk("rst_if_done", 32'(bus.if_done), 32'd0);
      chk("rst_if_inst", bus.if_inst, 32'd0);
      chk("rst_mem_a", bus.mem_a, 32'd0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // SW of 0x12345678 to 0x100 (RAM becomes 78 56 34 12), then LW.
      xact(1, 32'h100, 4, 32'h1234_5678, 0, 0, -1, 0, dc, act, d, wrs);
      ref_store(32'h100, 4, 32'h1234_5678);
      chk("sw_done_cyc", dc, 32'd5);
      chk("sw_writes", wrs, 32'd4);
      xact(0, 32'h100, 4, 0, 0, 0, -1, 0, dc, act, d, wrs);
      chk("lw_done_cyc", dc, 32'd6);
      chk("lw_data", d, 32'h1234_5678);
      for (int k = 1; k <= 4; k++) begin
         chk("lw_addr", tr_a[k], 32'h100 + 32'(k - 1));
         chk("lw_wr", 32'(tr_wr[k]), 32'd0);
      end

      // SB: one byte written, neighbour untouched.
      xact(1, 32'h200, 1, 32'hDEAD_BEEF, 0, 0, -1, 0, dc, act, d, wrs);
      ref_store(32'h200, 1, 32'hDEAD_BEEF);
      chk("sb_done_cyc", dc, 32'd2);
      chk("sb_wr", 32'(tr_wr[1]), 32'd1);
      chk("sb_addr", tr_a[1], 32'h200);
      chk("sb_dout", 32'(tr_dout[1]), 32'hEF);
      xact(0, 32'h200, 2, 0, 0, 0, -1, 0, dc, act, d, wrs);
      chk("sb_lh_data", d, {16'h0, init_byte(32'h201), 8'hEF});

      // Arbitration: LH at 0x10 (CD AB) and fetch at 0x100 raised together.
      xact(1, 32'h10, 2, 32'h0000_ABCD, 0, 0, -1, 0, dc, act, d, wrs);
      ref_store(32'h10, 2, 32'h0000_ABCD);
      bus.ls_sig = 1'b1; bus.load_or_store = 1'b0; bus.len = 3'b010; bus.ls_addr = 32'h10;
      bus.if_sig = 1'b1; bus.if_addr = 32'h100;
      ls_c = -1; if_c = -1; ld = '0; id = '0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.ls_done && ls_c < 0) begin ls_c = c; ld = bus.ls_data; end
         if (bus.if_done && if_c < 0) begin if_c = c; id = bus.if_inst; end
         @(posedge clk); #1;
         if (ls_c >= 0) bus.ls_sig = 1'b0;
         if (if_c >= 0) begin bus.if_sig = 1'b0; break; end
      end
      bus.ls_sig = 1'b0; bus.if_sig = 1'b0;
      chk("arb_ls_cyc", ls_c, 32'd4);
      chk("arb_ls_data", ld, 32'h0000_ABCD);
      chk("arb_if_cyc", if_c, 32'd11);
      chk("arb_if_inst", id, ref_load(32'h100, 4));

      // Flush: fetch aborted, block idle right after; LW survives clear.
      xact(2, 32'h0, 4, 0, 0, 0, 2, 0, dc, act, d, wrs);
      chk("flush_fetch_done", dc, -1);
      xact(0, 32'h100, 4, 0, 0, 0, -1, 0, dc, act, d, wrs);
      chk("post_flush_lw_cyc", dc, 32'd6);
      xact(0, 32'h100, 4, 0, 0, 0, 2, 0, dc, act, d, wrs);
      chk("flush_lw_cyc", dc, 32'd6);
      chk("flush_lw_data", d, 32'h1234_5678);

      // rdy pauses on a load and on a store.
      xact(0, 32'h100, 4, 0, 32'b1100, 0, -1, 0, dc, act, d, wrs);
      chk("pause_lw_cyc", dc, 32'd8);
      chk("pause_lw_data", d, 32'h1234_5678);
      xact(1, 32'h300, 4, 32'hA1B2_C3D4, 32'b0110, 0, -1, 0, dc, act, d, wrs);
      ref_store(32'h300, 4, 32'hA1B2_C3D4);
      chk("pause_sw_cyc", dc, 32'd7);
      chk("pause_sw_writes", wrs, 32'd4);

      // IO-space store with the sink full for cycles 1-3.
      xact(1, 32'h0003_0000, 1, 32'h0000_0077, 0, 32'b1110, -1, 0, dc, act, d, wrs);
      ref_store(32'h0003_0000, 1, 32'h0000_0077);
      chk("io_writes", wrs, 32'd1);
`ifdef MEM_CTRL_IO_STALL_EN
      chk("io_done_cyc", dc, 32'd5);
      chk("io_wr_stalled", 32'(tr_wr[1]), 32'd0);
      chk("io_wr_release", 32'(tr_wr[4]), 32'd1);
`else
      chk("io_done_cyc", dc, 32'd2);
      chk("io_wr_first", 32'(tr_wr[1]), 32'd1);
`endif

      // Address wrap at the top of the space.
      xact(1, 32'hFFFF_FFFE, 4, 32'h0BAD_F00D, 0, 0, -1, 0, dc, act, d, wrs);
      ref_store(32'hFFFF_FFFE, 4, 32'h0BAD_F00D);
      xact(0, 32'hFFFF_FFFE, 4, 0, 0, 0, -1, 0, dc, act, d, wrs);
      chk("wrap_addr2", tr_a[3], 32'h0);
      chk("wrap_addr3", tr_a[4], 32'h1);
      chk("wrap_data", d, ref_load(32'hFFFF_FFFE, 4));

      // Random traffic with random rdy.
      for (int t = 0; t < 80; t++) begin
         kind = $urandom_range(0, 2);
         case ($urandom_range(0, 2))
            0:       n = 1;
            1:       n = 2;
            default: n = 4;
         endcase
         if (kind == 2) n = 4;
         addr = 32'($urandom_range(0, 1023));
         sval = $urandom;
         xact(kind, addr, n, sval, 0, 0, -1, 1, dc, act, d, wrs);
         if (kind == 1) begin
            chk("rnd_st_lat", act, 32'(n + 1));
            chk("rnd_st_writes", wrs, 32'(n));
            ref_store(addr, n, sval);
         end else begin
            chk("rnd_ld_lat", act, 32'(n + 2));
            chk("rnd_ld_data", d, ref_load(addr, n));
         end
      end

      chk("frozen_writes", frozen_wr, 32'd0);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
      chk("mem_image", bad, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
